// File: rtl/block_unpack_fifo.sv
// block_unpack_fifo
//   A FIFO that stores whole BLOCK_W-bit blocks and returns them one
//   WORD_W-bit word at a time. Word order within a block is chosen by
//   MSW_FIRST. A block slot is freed only after its last word is read.
//
// Parameters
//   BLOCK_W   input block width (integer multiple of WORD_W)
//   WORD_W    output word width (BLOCK_W/WORD_W >= 2)
//   DEPTH     number of block slots (power of 2, >= 2)
//   MSW_FIRST 1 = most-significant word first, 0 = least-significant first
//
// Ports
//   clk          sole clock, rising edge
//   n_rst        synchronous active-low reset
//   write_en     push one block (ignored while fifo_full)
//   data_in      block to push
//   read_en      pop one word (ignored while fifo_empty)
//   data_out     registered last-popped word
//   fifo_empty   no words available
//   fifo_full    all DEPTH slots occupied
//   block_count  occupied slots, including a partially read head block
//
// Optional build macro FIFO_OUT_ERR_EN adds:
//   err_clr      clears the sticky error flags
//   overflow     sticky, set by a rejected write
//   underflow    sticky, set by a rejected read

module block_unpack_fifo #(
  parameter int BLOCK_W   = 128,
  parameter int WORD_W    = 32,
  parameter int DEPTH     = 4,
  parameter int MSW_FIRST = 1
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         write_en,
  input  logic [BLOCK_W-1:0]           data_in,
  input  logic                         read_en,
`ifdef FIFO_OUT_ERR_EN
  input  logic                         err_clr,
  output logic                         overflow,
  output logic                         underflow,
`endif
  output logic [WORD_W-1:0]            data_out,
  output logic                         fifo_empty,
  output logic                         fifo_full,
  output logic [$clog2(DEPTH+1)-1:0]   block_count
);

  localparam int NWORDS = BLOCK_W / WORD_W;
  localparam int AW     = $clog2(DEPTH);
  localparam int WI     = $clog2(NWORDS);
  localparam int CW     = $clog2(DEPTH + 1);

  localparam logic [WI-1:0] LAST_IDX = WI'(NWORDS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Block storage; not reset, the pointers define what is valid.
  logic [BLOCK_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic [WI-1:0]     widx_q, widx_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WORD_W-1:0] dout_q, dout_d;

  logic wr_acc;
  logic rd_acc;
  logic rd_last;

  logic [BLOCK_W-1:0] head_block;
  logic [WORD_W-1:0]  head_words [NWORDS];
  logic [WI-1:0]      sel_idx;

  // Status is derived purely from the registered count.
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == FULL_CNT);
  assign block_count = count_q;
  assign data_out    = dout_q;

  assign wr_acc  = write_en && !fifo_full;
  assign rd_acc  = read_en && !fifo_empty;
  assign rd_last = rd_acc && (widx_q == LAST_IDX);

  // Slice the head block into words; word gi sits at bits gi*WORD_W.
  assign head_block = mem_q[head_q];
  generate
    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_words
      assign head_words[gi] = head_block[gi*WORD_W +: WORD_W];
    end
  endgenerate

  // The word index counts reads; map it to a physical word position.
  generate
    if (MSW_FIRST != 0) begin : g_msw
      assign sel_idx = LAST_IDX - widx_q;
    end else begin : g_lsw
      assign sel_idx = widx_q;
    end
  endgenerate

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    widx_d  = widx_q;
    count_d = count_q;
    dout_d  = dout_q;

    if (wr_acc) begin
      tail_d = tail_q + 1'b1;  // DEPTH is a power of 2: natural wrap
    end

    if (rd_acc) begin
      dout_d = head_words[sel_idx];
      if (rd_last) begin
        widx_d = '0;
        head_d = head_q + 1'b1;
      end else begin
        widx_d = widx_q + 1'b1;
      end
    end

    // A block enters on an accepted write and leaves on its last-word read.
    case ({wr_acc, rd_last})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      widx_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      widx_q  <= widx_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst && wr_acc) begin
      mem_q[tail_q] <= data_in;
    end
  end

`ifdef FIFO_OUT_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A new error on the clearing edge wins over err_clr.
  always_comb begin
    overflow_d  = (overflow_q  && !err_clr) || (write_en && fifo_full);
    underflow_d = (underflow_q && !err_clr) || (read_en  && fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_block_unpack_fifo.sv
// Directed bench for block_unpack_fifo: a default instance (128/32, DEPTH 4,
// MSW first) and a byte-wide LSW-first instance.
module tb_block_unpack_fifo;

  logic clk = 1'b0;
  logic n_rst;

  logic         write_en, read_en;
  logic [127:0] data_in;
  logic [31:0]  data_out;
  logic         fifo_empty, fifo_full;
  logic [2:0]   block_count;

  logic         write_en8, read_en8;
  logic [127:0] data_in8;
  logic [7:0]   data_out8;
  logic         fifo_empty8, fifo_full8;
  logic [2:0]   block_count8;

`ifdef FIFO_OUT_ERR_EN
  logic err_clr, overflow, underflow;
  logic err_clr8, overflow8, underflow8;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  block_unpack_fifo dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .write_en    (write_en),
    .data_in     (data_in),
    .read_en     (read_en),
`ifdef FIFO_OUT_ERR_EN
    .err_clr     (err_clr),
    .overflow    (overflow),
    .underflow   (underflow),
`endif
    .data_out    (data_out),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .block_count (block_count)
  );

  block_unpack_fifo #(.BLOCK_W(128), .WORD_W(8), .DEPTH(4), .MSW_FIRST(0)) dut8 (
    .clk         (clk),
    .n_rst       (n_rst),
    .write_en    (write_en8),
    .data_in     (data_in8),
    .read_en     (read_en8),
`ifdef FIFO_OUT_ERR_EN
    .err_clr     (err_clr8),
    .overflow    (overflow8),
    .underflow   (underflow8),
`endif
    .data_out    (data_out8),
    .fifo_empty  (fifo_empty8),
    .fifo_full   (fifo_full8),
    .block_count (block_count8)
  );

  // Block k holds words k*16+0 .. k*16+3, word 0 in the top 32 bits.
  function automatic logic [127:0] blk(input int k);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) r[127-32*j -: 32] = 32'(k*16 + j);
    return r;
  endfunction

  function automatic logic [127:0] wrd(input int k, input int j);
    return 128'(32'(k*16 + j));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_rst = 1'b0; write_en = 1'b0; read_en = 1'b0; data_in = '0;
    write_en8 = 1'b0; read_en8 = 1'b0; data_in8 = '0;
`ifdef FIFO_OUT_ERR_EN
    err_clr = 1'b0; err_clr8 = 1'b0;
`endif

    // Reset then idle
    tick(); tick();
    n_rst = 1'b1;
    tick();
    chk("rst_empty", 128'(fifo_empty), 128'(1'b1));
    chk("rst_full", 128'(fifo_full), 128'(1'b0));
    chk("rst_count", 128'(block_count), 128'(3'd0));
    chk("rst_dout", 128'(data_out), 128'(32'h0));
    chk("rst_dout8", 128'(data_out8), 128'(8'h0));
    $display("step reset: empty=%0d full=%0d count=%0d", fifo_empty, fifo_full, block_count);

    // One block, four MSW-first reads
    write_en = 1'b1; data_in = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
    tick();
    write_en = 1'b0;
    chk("w1_count", 128'(block_count), 128'(3'd1));
    chk("w1_empty", 128'(fifo_empty), 128'(1'b0));
    read_en = 1'b1;
    tick(); chk("rd_a", 128'(data_out), 128'(32'hAAAAAAAA));
    tick(); chk("rd_b", 128'(data_out), 128'(32'hBBBBBBBB));
    tick(); chk("rd_c", 128'(data_out), 128'(32'hCCCCCCCC));
    tick(); chk("rd_d", 128'(data_out), 128'(32'hDDDDDDDD));
    chk("rd_empty", 128'(fifo_empty), 128'(1'b1));
    chk("rd_count0", 128'(block_count), 128'(3'd0));
    tick();  // read on empty: ignored, data_out holds
    read_en = 1'b0;
    chk("uf_hold", 128'(data_out), 128'(32'hDDDDDDDD));
`ifdef FIFO_OUT_ERR_EN
    chk("uf_flag", 128'(underflow), 128'(1'b1));
`endif
    $display("step msw: last word %h count=%0d", data_out, block_count);

    // Byte-wide LSW-first instance
    write_en8 = 1'b1; data_in8 = 128'h100F0E0D0C0B0A090807060504030201;
    tick();
    write_en8 = 1'b0; read_en8 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("lsw_byte%0d", i), 128'(data_out8), 128'(8'(i + 1)));
    end
    read_en8 = 1'b0;
    chk("lsw_count0", 128'(block_count8), 128'(3'd0));
    chk("lsw_empty", 128'(fifo_empty8), 128'(1'b1));
    $display("step lsw: last byte %h count=%0d", data_out8, block_count8);

    // Five writes into DEPTH=4: fifth dropped, pointers wrap
    write_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      data_in = blk(k);
      tick();
    end
    chk("fill_full", 128'(fifo_full), 128'(1'b1));
    chk("fill_count", 128'(block_count), 128'(3'd4));
    data_in = blk(99);
    tick();
    write_en = 1'b0;
    chk("ovf_count", 128'(block_count), 128'(3'd4));
`ifdef FIFO_OUT_ERR_EN
    chk("ovf_flag", 128'(overflow), 128'(1'b1));
`endif
    read_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        tick();
        chk($sformatf("drain1_b%0d_w%0d", k, j), 128'(data_out), wrd(k, j));
      end
    end
    read_en = 1'b0;
    chk("drain1_empty", 128'(fifo_empty), 128'(1'b1));
    $display("step overflow/drain: count=%0d empty=%0d", block_count, fifo_empty);

    // Full FIFO, write with last-word read on the same edge: write rejected
    write_en = 1'b1;
    for (int k = 5; k <= 8; k++) begin
      data_in = blk(k);
      tick();
    end
    write_en = 1'b0; read_en = 1'b1;
    tick(); tick(); tick();
    write_en = 1'b1; data_in = blk(9);
    tick();
    chk("same_edge_count", 128'(block_count), 128'(3'd3));
    chk("same_edge_dout", 128'(data_out), wrd(5, 3));
    read_en = 1'b0;
    tick();
    write_en = 1'b0;
    chk("retry_count", 128'(block_count), 128'(3'd4));
    chk("retry_full", 128'(fifo_full), 128'(1'b1));
    read_en = 1'b1;
    for (int k = 6; k <= 9; k++) begin
      for (int j = 0; j < 4; j++) begin
        tick();
        chk($sformatf("drain2_b%0d_w%0d", k, j), 128'(data_out), wrd(k, j));
      end
    end
    read_en = 1'b0;
    chk("drain2_empty", 128'(fifo_empty), 128'(1'b1));
    $display("step same-edge: count=%0d empty=%0d", block_count, fifo_empty);

    // Reset mid-operation discards everything
    write_en = 1'b1;
    data_in = blk(10); tick();
    data_in = blk(11); tick();
    write_en = 1'b0; read_en = 1'b1;
    tick(); tick();
    n_rst = 1'b0; write_en = 1'b1; data_in = blk(13);
    tick();
    chk("mrst_empty", 128'(fifo_empty), 128'(1'b1));
    chk("mrst_count", 128'(block_count), 128'(3'd0));
    chk("mrst_dout", 128'(data_out), 128'(32'h0));
    n_rst = 1'b1; read_en = 1'b0; data_in = blk(12);
    tick();
    write_en = 1'b0; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    chk("post_rst_dout", 128'(data_out), wrd(12, 0));
    chk("post_rst_count", 128'(block_count), 128'(3'd1));
    $display("step mid-reset: dout=%h count=%0d", data_out, block_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/block_unpack_fifo.md
BLOCK_UNPACK_FIFO -- requirements
Module: block_unpack_fifo

Interface
REQ-001 SHALL have parameter BLOCK_W, default 128, input block width in bits.
REQ-002 SHALL have parameter WORD_W, default 32, output word width; BLOCK_W SHALL be an integer multiple of it, so NWORDS = BLOCK_W/WORD_W >= 2.
REQ-003 SHALL have parameter DEPTH, default 4, number of stored blocks; a power of 2, >= 2.
REQ-004 SHALL have parameter MSW_FIRST, default 1; 1 = most-significant word read first, 0 = least-significant first.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 n_rst  input  1  synchronous active-low reset, sampled on rising clk.
REQ-007 write_en  input  1  request to push one block.
REQ-008 data_in  input  BLOCK_W  block to push.
REQ-009 read_en  input  1  request to pop one word.
REQ-010 data_out  output  WORD_W  registered last-popped word.
REQ-011 fifo_empty  output  1  no words available.
REQ-012 fifo_full  output  1  DEPTH block slots occupied.
REQ-013 block_count  output  clog2(DEPTH+1)  occupied block slots, including a partially read head block.

Function
REQ-014 Write accepted on a rising edge iff write_en=1 and fifo_full=0 before the edge; data_in stored at the tail; tail pointer increments modulo DEPTH.
REQ-015 Read accepted on a rising edge iff read_en=1 and fifo_empty=0 before the edge; the selected word of the head block loads into data_out on that edge (1-cycle latency); word index increments.
REQ-016 Word order for MSW_FIRST=1: data_in[BLOCK_W-1 -: WORD_W] first, down to bits [WORD_W-1:0]; MSW_FIRST=0 reverses the order.
REQ-017 When word index reaches NWORDS-1 and is read, index returns to 0, head pointer increments modulo DEPTH, block_count decrements.
REQ-018 Simultaneous accepted write and last-word read: block_count unchanged; both pointers advance.
REQ-019 Write while fifo_full=1 is ignored, even if the same edge frees a slot; no data corruption.
REQ-020 Read while fifo_empty=1 is ignored; data_out holds.
REQ-021 data_out holds its value on every edge without an accepted read.
REQ-022 fifo_empty = (block_count==0); fifo_full = (block_count==DEPTH); both registered/derived from registered state, valid the cycle after the causing edge.
REQ-023 Pointers wrap from DEPTH-1 to 0 without loss; DEPTH consecutive write/drain cycles preserve order.

Reset
REQ-024 On a rising edge with n_rst=0: data_out=0, block_count=0, fifo_empty=1, fifo_full=0, pointers and word index=0; error flags (if compiled) = 0.
REQ-025 Reset mid-operation discards all stored blocks and any partially read block; write_en/read_en ignored on that edge.
REQ-026 Storage array contents need not be cleared by reset.

Configuration
REQ-027 Macro FIFO_OUT_ERR_EN defined: adds input err_clr (1 bit) and outputs overflow, underflow (1 bit each).
REQ-028 With FIFO_OUT_ERR_EN: overflow set on any rejected write; underflow set on any rejected read; both sticky until err_clr=1 or reset; a new error on the clearing edge wins (flag stays 1).
REQ-029 Without FIFO_OUT_ERR_EN: those three ports do not exist; rejected operations are silently ignored, all other behaviour identical.

Verification
REQ-030 Reset then idle -> fifo_empty=1, fifo_full=0, block_count=0, data_out=0.
REQ-031 Defaults; write AAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, then 4 single-cycle reads -> data_out AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD; fifo_empty=1 after fourth.
REQ-032 MSW_FIRST=0, WORD_W=8, write 128'h00..0F0E..01 pattern -> bytes emerge LSB first: 01, 02 ... ; block_count drops to 0 after 16 reads.
REQ-033 Write 5 distinct blocks with DEPTH=4 -> fifo_full=1 after 4th, 5th dropped (overflow=1 with FIFO_OUT_ERR_EN); drain 16 words in order of blocks 1-4.
REQ-034 Full FIFO, write_en with read of last word of head on same edge -> write rejected, block_count=3; next cycle write accepted, block_count=4.
REQ-035 Two blocks loaded, 2 words read, n_rst=0 one edge -> fifo_empty=1, block_count=0, data_out=0; subsequent write/read returns the new block's first word.
